fmc_i2c_cfg_sequencer: RTL and testbench
========================================

# fmc_i2c_cfg_sequencer

Walks a fixed table of I2C register writes that brings up the FMC424 (CPLD control registers, SI5338B clock generator, QSFP modules). For each entry it issues one byte-level transaction to the I2C master engine, optionally reads the register back to verify it, and retries on NACK or mismatch. It sits between board-level enable logic and the I2C master that drives SCL_PIN/SDA_PIN. It is the only client of that engine during bring-up.

## Interface
- NUM_ENTRIES, 8, table depth; legal range 1..256.
- MAX_RETRIES, 3, extra attempts per entry after the first failure; 0 means fail on the first error.
- GAP_CYCLES, 100, idle cycles enforced between consecutive transactions for bus-free time; legal range 1..65535.
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous, active-low reset.
- START  in  1  single-cycle pulse that begins a table walk; sampled only in IDLE, DONE or FAIL.
- BUSY  out  1  high from the cycle after START is accepted until DONE or FAIL is entered.
- CFG_DONE  out  1  level; all entries succeeded; cleared by the next accepted START.
- CFG_ERROR  out  1  level; an entry exhausted its retries; cleared by the next accepted START.
- ERR_INDEX  out  8  index of the failing entry; valid while CFG_ERROR=1.
- CMD_VALID  out  1  transaction request to the I2C engine.
- CMD_READY  in  1  engine accepts the request when CMD_VALID && CMD_READY.
- CMD_RW  out  1  0 = write, 1 = read.
- CMD_DEV  out  7  7-bit device address.
- CMD_REG  out  8  register address.
- CMD_DATA  out  8  write data; don't-care for reads.
- RSP_VALID  in  1  one-cycle completion strobe from the engine.
- RSP_NACK  in  1  qualified by RSP_VALID; any NACK during the transaction.
- RSP_DATA  in  8  qualified by RSP_VALID; read data.

## Operation
- Entry format, 24 bits: {verify[23], dev[22:16], reg[15:8], data[7:0]}. The entries come from the ROM sub-module.
- States:
  - IDLE: START → FETCH; idx=0, retry=0, CFG_DONE=0, CFG_ERROR=0.
  - FETCH: drive the ROM address; after 1 cycle latch the entry → ISSUE_W.
  - ISSUE_W: CMD_VALID=1, CMD_RW=0; on handshake → WAIT_W.
  - WAIT_W: on RSP_VALID:
    - NACK → RETRY.
    - Otherwise, verify set → GAP then ISSUE_R.
    - Otherwise → NEXT.
  - ISSUE_R: CMD_VALID=1, CMD_RW=1; on handshake → WAIT_R.
  - WAIT_R: on RSP_VALID:
    - NACK, or RSP_DATA != data → RETRY.
    - Otherwise → NEXT.
  - RETRY: if retry==MAX_RETRIES → FAIL, with ERR_INDEX=idx. Otherwise retry++, then GAP, then ISSUE_W.
  - NEXT: if idx==NUM_ENTRIES-1 → DONE. Otherwise idx++, retry=0, then GAP, then FETCH.
  - GAP: count GAP_CYCLES cycles, then go to the pending target state.
  - DONE / FAIL: hold the result flags; START → same action as from IDLE.
- CMD_* payload is registered and stays stable while CMD_VALID=1. CMD_VALID never drops before the handshake.
- RSP_VALID outside WAIT_W/WAIT_R is ignored.
- START while BUSY is ignored.
- The retry counter is sized $clog2(MAX_RETRIES+1), minimum 1 bit. The index is 8 bits, zero-extended onto ERR_INDEX.

## Timing
- Reset values: all outputs 0; state IDLE; idx, retry and gap counters 0.
- An accepted START (cycle N) gives BUSY=1 at N+1 and CMD_VALID=1 at N+3 (FETCH address cycle plus latch cycle).
- Request to completion: RSP_VALID at cycle M gives CMD_VALID for the next transaction no earlier than M+1+GAP_CYCLES.
- CFG_DONE/CFG_ERROR rise, and BUSY falls, in the same cycle, one cycle after the deciding RSP_VALID.
- RST_N asserted mid-transaction clears CMD_VALID immediately. The I2C engine shares RST_N, so there is no abort handshake.
- A single RSP_VALID coincident with CMD_READY is impossible by engine contract. If it occurs, the response is ignored.

## Structure
- The shared package fmc_i2c_pkg holds:
  - the entry struct and state enum;
  - device addresses CPLD_ADDR=7'h3E, SI5338B_ADDR=7'h70, QSFP_ADDR=7'h50;
  - CMD_RW encodings.
- Sub-module fmc_cfg_rom: parameterised depth, synchronous 1-cycle read, contents from a package constant array.
- The sequencer itself is one FSM plus idx, retry and gap counters.

## Test plan
- NUM_ENTRIES=2, no verify, engine always ACKs:
  - exactly 2 writes, with payloads matching the table;
  - CFG_DONE=1, BUSY=0, CMD_VALID first seen 2 cycles after BUSY rises.
- Entry 1 has verify=1 with data 8'hA5, and the engine returns 8'hA5: write then read to the same dev/reg, then DONE. With return 8'h5A instead, MAX_RETRIES=2: 3 write+read pairs, then CFG_ERROR=1 and ERR_INDEX=1.
- Engine NACKs the first write of entry 0, then ACKs: one retry, and the total write count is table size + 1; gap of ≥GAP_CYCLES before the re-issue.
- CMD_READY held low for 50 cycles: CMD_VALID and the payload stay constant every cycle; a START pulse during that time is ignored.
- RST_N pulsed low while in WAIT_R: all outputs return to 0 asynchronously. A following START restarts at entry 0.

Source files
------------

// File: rtl/fmc_i2c_pkg.sv
// Shared types, addresses and the FMC424 bring-up table for the I2C config sequencer.
package fmc_i2c_pkg;

  localparam int unsigned CFG_TABLE_DEPTH = 256;

  // 7-bit I2C device addresses on the FMC424
  localparam logic [6:0] CPLD_ADDR    = 7'h3E;
  localparam logic [6:0] SI5338B_ADDR = 7'h70;
  localparam logic [6:0] QSFP_ADDR    = 7'h50;

  // CMD_RW encodings
  localparam logic CMD_RW_WRITE = 1'b0;
  localparam logic CMD_RW_READ  = 1'b1;

  typedef struct packed {
    logic       verify;
    logic [6:0] dev;
    logic [7:0] reg_addr;
    logic [7:0] data;
  } cfg_entry_t;

  // Entry 0 occupies the least-significant 24 bits
  typedef logic [CFG_TABLE_DEPTH-1:0][23:0] cfg_table_t;

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StLatch,
    StIssueW,
    StWaitW,
    StIssueR,
    StWaitR,
    StGap,
    StDone,
    StFail
  } state_e;

  function automatic logic [23:0] cfg_entry(input logic       verify,
                                            input logic [6:0] dev,
                                            input logic [7:0] reg_addr,
                                            input logic [7:0] data);
    return {verify, dev, reg_addr, data};
  endfunction

  // Default bring-up: CPLD enables, SI5338B output disable / soft reset / enable, QSFP TX enable
  localparam cfg_table_t FMC424_CFG_TABLE = {
    {(CFG_TABLE_DEPTH - 8){24'h000000}},
    cfg_entry(1'b0, QSFP_ADDR,    8'h56, 8'h00),
    cfg_entry(1'b1, SI5338B_ADDR, 8'hE6, 8'h00),
    cfg_entry(1'b0, SI5338B_ADDR, 8'hF1, 8'h65),
    cfg_entry(1'b0, SI5338B_ADDR, 8'hF6, 8'h02),
    cfg_entry(1'b0, SI5338B_ADDR, 8'hF1, 8'hE5),
    cfg_entry(1'b0, SI5338B_ADDR, 8'hE6, 8'h10),
    cfg_entry(1'b1, CPLD_ADDR,    8'h03, 8'h0F),
    cfg_entry(1'b0, CPLD_ADDR,    8'h02, 8'h01)
  };

endpackage

// File: rtl/fmc_cfg_rom.sv
// Synchronous 1-cycle-read ROM holding the configuration table.
module fmc_cfg_rom
  import fmc_i2c_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter cfg_table_t  TABLE = FMC424_CFG_TABLE
) (
  input  logic        clk,
  input  logic [7:0]  addr,
  output logic [23:0] data
);

  // Registered read; addresses past the configured depth read as zero
  always_ff @(posedge clk) begin
    if (32'(addr) < DEPTH) begin
      data <= TABLE[addr];
    end else begin
      data <= '0;
    end
  end

endmodule

// File: rtl/fmc_i2c_cfg_sequencer.sv
// Walks the config table, issuing one I2C write (plus optional read-back) per entry with retries.
module fmc_i2c_cfg_sequencer
  import fmc_i2c_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned MAX_RETRIES = 3,
  parameter int unsigned GAP_CYCLES  = 100,
  parameter cfg_table_t  CFG_TABLE   = FMC424_CFG_TABLE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       cfg_done,
  output logic       cfg_error,
  output logic [7:0] err_index,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       cmd_rw,
  output logic [6:0] cmd_dev,
  output logic [7:0] cmd_reg,
  output logic [7:0] cmd_data,
  input  logic       rsp_valid,
  input  logic       rsp_nack,
  input  logic [7:0] rsp_data
);

  localparam int unsigned     RetryW   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRIES);
  localparam logic [7:0]      LastIdx  = 8'(NUM_ENTRIES - 1);
  localparam logic [15:0]     GapLast  = 16'(GAP_CYCLES - 1);

  state_e            state_q, state_d;
  state_e            gap_tgt_q, gap_tgt_d;
  logic [7:0]        idx_q, idx_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [15:0]       gap_cnt_q, gap_cnt_d;
  cfg_entry_t        entry_q, entry_d;
  logic              cmd_rw_q, cmd_rw_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [7:0]        err_idx_q, err_idx_d;
  logic [23:0]       rom_data;
  logic              do_retry, do_next;

  fmc_cfg_rom #(
    .DEPTH (NUM_ENTRIES),
    .TABLE (CFG_TABLE)
  ) u_rom (
    .clk  (clk),
    .addr (idx_q),
    .data (rom_data)
  );

  // State, counters, latched entry and result flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      gap_tgt_q <= StIdle;
      idx_q     <= '0;
      retry_q   <= '0;
      gap_cnt_q <= '0;
      entry_q   <= '0;
      cmd_rw_q  <= CMD_RW_WRITE;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      gap_tgt_q <= gap_tgt_d;
      idx_q     <= idx_d;
      retry_q   <= retry_d;
      gap_cnt_q <= gap_cnt_d;
      entry_q   <= entry_d;
      cmd_rw_q  <= cmd_rw_d;
      done_q    <= done_d;
      error_q   <= error_d;
      err_idx_q <= err_idx_d;
    end
  end

  // Next-state logic; retry/next decisions resolve in the response cycle so the result
  // flags appear one cycle after the deciding response.
  always_comb begin
    state_d   = state_q;
    gap_tgt_d = gap_tgt_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    gap_cnt_d = gap_cnt_q;
    entry_d   = entry_q;
    cmd_rw_d  = cmd_rw_q;
    done_d    = done_q;
    error_d   = error_q;
    err_idx_d = err_idx_q;
    do_retry  = 1'b0;
    do_next   = 1'b0;

    case (state_q)
      StIdle, StDone, StFail: begin
        if (start) begin
          state_d   = StFetch;
          idx_d     = '0;
          retry_d   = '0;
          done_d    = 1'b0;
          error_d   = 1'b0;
          err_idx_d = '0;
        end
      end
      StFetch: state_d = StLatch;
      StLatch: begin
        entry_d  = cfg_entry_t'(rom_data);
        cmd_rw_d = CMD_RW_WRITE;
        state_d  = StIssueW;
      end
      StIssueW: begin
        if (cmd_ready) state_d = StWaitW;
      end
      StWaitW: begin
        if (rsp_valid) begin
          if (rsp_nack) begin
            do_retry = 1'b1;
          end else if (entry_q.verify) begin
            cmd_rw_d  = CMD_RW_READ;
            gap_tgt_d = StIssueR;
            state_d   = StGap;
          end else begin
            do_next = 1'b1;
          end
        end
      end
      StIssueR: begin
        if (cmd_ready) state_d = StWaitR;
      end
      StWaitR: begin
        if (rsp_valid) begin
          if (rsp_nack || (rsp_data != entry_q.data)) begin
            do_retry = 1'b1;
          end else begin
            do_next = 1'b1;
          end
        end
      end
      StGap: begin
        if (gap_cnt_q == GapLast) begin
          gap_cnt_d = '0;
          state_d   = gap_tgt_q;
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (do_retry) begin
      if (retry_q == RetryMax) begin
        state_d   = StFail;
        error_d   = 1'b1;
        err_idx_d = idx_q;
      end else begin
        retry_d   = retry_q + 1'b1;
        cmd_rw_d  = CMD_RW_WRITE;
        gap_tgt_d = StIssueW;
        state_d   = StGap;
      end
    end

    if (do_next) begin
      if (idx_q == LastIdx) begin
        state_d = StDone;
        done_d  = 1'b1;
      end else begin
        idx_d     = idx_q + 8'd1;
        retry_d   = '0;
        gap_tgt_d = StFetch;
        state_d   = StGap;
      end
    end
  end

  // Outputs are decoded from registered state only
  always_comb begin
    cmd_valid = (state_q == StIssueW) || (state_q == StIssueR);
    busy      = !((state_q == StIdle) || (state_q == StDone) || (state_q == StFail));
    cmd_rw    = cmd_rw_q;
    cmd_dev   = entry_q.dev;
    cmd_reg   = entry_q.reg_addr;
    cmd_data  = entry_q.data;
    cfg_done  = done_q;
    cfg_error = error_q;
    err_index = err_idx_q;
  end

endmodule

// File: tb/tb_fmc_i2c_cfg_sequencer.sv
// Self-checking bench: a cycle-stepped I2C engine model serves two sequencer instances.
module tb_fmc_i2c_cfg_sequencer;
  import fmc_i2c_pkg::*;

  // Instance A: 2 entries, no verify. Instance B: 4 entries, two with read-back verify.
  localparam cfg_table_t TBL_A = {
    {(CFG_TABLE_DEPTH - 2){24'h000000}},
    cfg_entry(1'b0, SI5338B_ADDR, 8'hE6, 8'h10),
    cfg_entry(1'b0, CPLD_ADDR,    8'h01, 8'h3C)
  };
  localparam cfg_table_t TBL_B = {
    {(CFG_TABLE_DEPTH - 4){24'h000000}},
    cfg_entry(1'b0, QSFP_ADDR,    8'h56, 8'h00),
    cfg_entry(1'b1, SI5338B_ADDR, 8'hF1, 8'hE5),
    cfg_entry(1'b1, CPLD_ADDR,    8'h10, 8'hA5),
    cfg_entry(1'b0, CPLD_ADDR,    8'h02, 8'h01)
  };

  typedef struct {
    logic       rw;
    logic [6:0] dev;
    logic [7:0] rg;
    logic [7:0] data;
    logic       nack;
    logic [7:0] rdata;
  } txn_t;

  logic clk, rst_n, sel;
  logic start, cmd_ready, rsp_valid, rsp_nack;
  logic [7:0] rsp_data;
  logic start_a, ready_a, rspv_a, start_b, ready_b, rspv_b;
  logic busy_a, done_a, err_a, valid_a, rw_a, busy_b, done_b, err_b, valid_b, rw_b;
  logic [7:0] eidx_a, reg_a, data_a, eidx_b, reg_b, data_b;
  logic [6:0] dev_a, dev_b;
  logic busy, cfg_done, cfg_error, cmd_valid, cmd_rw;
  logic [7:0] err_index, cmd_reg, cmd_data;
  logic [6:0] cmd_dev;

  int   checks = 0;
  int   failures = 0;
  txn_t exp_q[$];
  logic exp_done, exp_err;
  int   exp_idx, n_wr, n_rd, hold_left;

  assign start_a = start & ~sel;
  assign ready_a = cmd_ready & ~sel;
  assign rspv_a  = rsp_valid & ~sel;
  assign start_b = start & sel;
  assign ready_b = cmd_ready & sel;
  assign rspv_b  = rsp_valid & sel;

  assign busy      = sel ? busy_b  : busy_a;
  assign cfg_done  = sel ? done_b  : done_a;
  assign cfg_error = sel ? err_b   : err_a;
  assign err_index = sel ? eidx_b  : eidx_a;
  assign cmd_valid = sel ? valid_b : valid_a;
  assign cmd_rw    = sel ? rw_b    : rw_a;
  assign cmd_dev   = sel ? dev_b   : dev_a;
  assign cmd_reg   = sel ? reg_b   : reg_a;
  assign cmd_data  = sel ? data_b  : data_a;

  fmc_i2c_cfg_sequencer #(
    .NUM_ENTRIES (2), .MAX_RETRIES (1), .GAP_CYCLES (4), .CFG_TABLE (TBL_A)
  ) dut_a (
    .clk (clk), .rst_n (rst_n), .start (start_a), .busy (busy_a), .cfg_done (done_a),
    .cfg_error (err_a), .err_index (eidx_a), .cmd_valid (valid_a), .cmd_ready (ready_a),
    .cmd_rw (rw_a), .cmd_dev (dev_a), .cmd_reg (reg_a), .cmd_data (data_a),
    .rsp_valid (rspv_a), .rsp_nack (rsp_nack), .rsp_data (rsp_data)
  );

  fmc_i2c_cfg_sequencer #(
    .NUM_ENTRIES (4), .MAX_RETRIES (2), .GAP_CYCLES (6), .CFG_TABLE (TBL_B)
  ) dut_b (
    .clk (clk), .rst_n (rst_n), .start (start_b), .busy (busy_b), .cfg_done (done_b),
    .cfg_error (err_b), .err_index (eidx_b), .cmd_valid (valid_b), .cmd_ready (ready_b),
    .cmd_rw (rw_b), .cmd_dev (dev_b), .cmd_reg (reg_b), .cmd_data (data_b),
    .rsp_valid (rspv_b), .rsp_nack (rsp_nack), .rsp_data (rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_min(input string tag, input int obs, input int min);
    checks++;
    assert ((obs >= min) === 1'b1) else begin
      failures++;
      $error("FAIL %s observed=%0d required_at_least=%0d", tag, obs, min);
    end
  endtask

  // Reference model: expand the table into the exact transaction list the sequencer must
  // issue, given pre-drawn engine responses. mode 0 all good, 1 random, 2 NACK first
  // write of entry 0, 3 every read returns 8'h5A.
  task automatic build_script(input logic s, input int mode);
    int         n, mr;
    logic [23:0] e;
    bit          ok;
    txn_t        t;
    n  = s ? 4 : 2;
    mr = s ? 2 : 1;
    exp_q.delete();
    exp_done = 1'b1;
    exp_err  = 1'b0;
    exp_idx  = 0;
    for (int i = 0; i < n; i++) begin
      e  = s ? TBL_B[i] : TBL_A[i];
      ok = 1'b0;
      for (int a = 0; a <= mr && !ok; a++) begin
        t.rw    = 1'b0;
        t.dev   = e[22:16];
        t.rg    = e[15:8];
        t.data  = e[7:0];
        t.rdata = 8'h00;
        t.nack  = (mode == 1) ? ($urandom_range(0, 3) == 0) : (mode == 2 && i == 0 && a == 0);
        exp_q.push_back(t);
        if (t.nack) continue;
        if (!e[23]) begin
          ok = 1'b1;
          continue;
        end
        t.rw   = 1'b1;
        t.nack = (mode == 1) && ($urandom_range(0, 5) == 0);
        if (mode == 3) t.rdata = 8'h5A;
        else if (mode == 1 && $urandom_range(0, 3) == 0)
          t.rdata = e[7:0] ^ 8'($urandom_range(1, 255));
        else t.rdata = e[7:0];
        exp_q.push_back(t);
        ok = !t.nack && (t.rdata == e[7:0]);
      end
      if (!ok) begin
        exp_done = 1'b0;
        exp_err  = 1'b1;
        exp_idx  = i;
        break;
      end
    end
  endtask

  // Start a walk on the selected instance and act as the I2C engine until it finishes.
  // With abort_rd set, RST_N is pulsed while the first read is outstanding.
  task automatic run_walk(input bit abort_rd);
    int   cyc, last_rsp, pend_cnt, gap;
    bit   pend, prev_valid, prev_hs, abort;
    txn_t cur;
    logic [23:0] prev_pl;
    gap = sel ? 6 : 4;
    n_wr = 0; n_rd = 0; pend = 0; prev_valid = 0; prev_hs = 0; abort = 0;
    last_rsp = -1; cyc = 0; pend_cnt = 0; prev_pl = '0;
    cur = '{default: '0};
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_at_n1", 32'(busy), 1);
    chk("valid_at_n1", 32'(cmd_valid), 0);
    @(posedge clk); #1;
    chk("valid_at_n2", 32'(cmd_valid), 0);
    @(posedge clk); #1;
    chk("valid_at_n3", 32'(cmd_valid), 1);
    while (cyc < 4000) begin
      start = 1'b0; rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_data = 8'h00;
      if (abort) begin
        rst_n = 1'b0;
        #2;
        chk("rst_outputs_zero", {busy, cfg_done, cfg_error, err_index, cmd_valid, cmd_rw,
                                 cmd_dev, cmd_reg}, 0);
        chk("rst_data_zero", 32'(cmd_data), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        return;
      end
      if (!busy) break;
      if (cmd_valid && prev_valid && !prev_hs)
        chk("payload_stable", 32'({cmd_rw, cmd_dev, cmd_reg, cmd_data}), 32'(prev_pl));
      if (cmd_valid && !prev_valid && last_rsp >= 0) chk_min("bus_gap", cyc - last_rsp, 1 + gap);
      if (pend) begin
        if (pend_cnt == 0) begin
          rsp_valid = 1'b1; rsp_nack = cur.nack; rsp_data = cur.rdata;
          pend = 0; last_rsp = cyc;
        end else pend_cnt--;
      end
      cmd_ready = 1'b1;
      if (cmd_valid && hold_left > 0) begin
        cmd_ready = 1'b0;
        hold_left--;
        if (hold_left == 25) start = 1'b1;
        if (hold_left == 24) chk("start_ignored_busy", 32'({busy, cfg_done}), 32'h2);
      end
      prev_hs = 1'b0;
      if (cmd_valid && cmd_ready) begin
        prev_hs = 1'b1;
        if (exp_q.size() == 0) chk("extra_txn", 32'(cmd_rw), 32'hFFFF);
        else begin
          cur = exp_q.pop_front();
          chk("txn_rw", 32'(cmd_rw), 32'(cur.rw));
          chk("txn_dev_reg", 32'({cmd_dev, cmd_reg}), 32'({cur.dev, cur.rg}));
          if (!cur.rw) chk("txn_wdata", 32'(cmd_data), 32'(cur.data));
        end
        if (cmd_rw) n_rd++; else n_wr++;
        pend = 1; pend_cnt = $urandom_range(0, 3);
        if (abort_rd && cmd_rw) abort = 1;
      end
      prev_valid = cmd_valid;
      prev_pl = {cmd_rw, cmd_dev, cmd_reg, cmd_data};
      @(posedge clk); #1;
      cyc++;
    end
    cmd_ready = 1'b0;
    chk("walk_finished", 32'(busy), 0);
    if (!busy) chk("flag_latency", cyc - last_rsp, 1);
    chk("cfg_done", 32'(cfg_done), 32'(exp_done));
    chk("cfg_error", 32'(cfg_error), 32'(exp_err));
    if (exp_err) chk("err_index", 32'(err_index), exp_idx);
    chk("script_drained", exp_q.size(), 0);
    chk("valid_idle", 32'(cmd_valid), 0);
  endtask

  initial begin
    rst_n = 1'b1; sel = 1'b0; start = 1'b0; cmd_ready = 1'b0;
    rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_data = 8'h00; hold_left = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_outputs_a", {busy_a, done_a, err_a, eidx_a, valid_a, rw_a, dev_a, reg_a}, 0);
    chk("reset_outputs_b", {busy_b, done_b, err_b, eidx_b, valid_b, rw_b, dev_b, reg_b}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset", 32'({busy_a, busy_b, valid_a, valid_b}), 0);

    // Two-entry table, no verify, engine always ACKs
    sel = 1'b0;
    build_script(1'b0, 0);
    run_walk(1'b0);
    chk("a_write_count", n_wr, 2);
    chk("a_read_count", n_rd, 0);

    // Read-back returns the written value
    sel = 1'b1;
    build_script(1'b1, 0);
    run_walk(1'b0);
    chk("b_ok_writes", n_wr, 4);
    chk("b_ok_reads", n_rd, 2);

    // Read-back always mismatches: entry 1 exhausts its retries
    build_script(1'b1, 3);
    run_walk(1'b0);
    chk("b_bad_writes", n_wr, 4);
    chk("b_bad_reads", n_rd, 3);

    // First write of entry 0 NACKed once
    build_script(1'b1, 2);
    run_walk(1'b0);
    chk("b_nack_writes", n_wr, 5);

    // Engine stalls 50 cycles with a START pulse in the middle
    hold_left = 50;
    build_script(1'b1, 0);
    run_walk(1'b0);
    chk("hold_consumed", hold_left, 0);

    // Reset while waiting for the read response, then a fresh walk from entry 0
    build_script(1'b1, 0);
    run_walk(1'b1);
    build_script(1'b1, 0);
    run_walk(1'b0);

    // Randomized engine responses on both instances
    for (int k = 0; k < 14; k++) begin
      sel = 1'($urandom_range(0, 1));
      build_script(sel, 1);
      run_walk(1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
